// File: rtl/instr_register_ctrl_pkg.sv
// Shared types for the instruction register controller.
//   opcode_t      : instruction opcode
//   operand_t     : signed 32-bit operand
//   address_t     : 5-bit register address (32 entries)
//   instruction_t : packed {opc, op_a, op_b}
//   COUNT_W       : occupancy counter width (holds 0..32)
package instr_register_pkg;

  localparam int unsigned COUNT_W = 6;

  typedef enum logic [3:0] {
    ZERO,
    PASSA,
    PASSB,
    ADD,
    SUB,
    MULT,
    DIV,
    MOD
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;
  typedef logic [COUNT_W-1:0] count_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

endpackage

// File: rtl/instr_register_ctrl_if.sv
// Bundle of the controller's request, read and register-drive signals.
//   slave  : controller side (instr_register_ctrl)
//   master : environment side (requesters, consumer, register array)
interface instr_register_ctrl_if;
  import instr_register_pkg::*;

  logic [1:0]   req_valid;
  opcode_t      req_opcode    [2];
  operand_t     req_operand_a [2];
  operand_t     req_operand_b [2];
  logic [1:0]   req_ready;

  logic         rd_valid;
  logic         rd_ready;
  instruction_t rd_instruction;

  logic         load_en;
  address_t     write_pointer;
  operand_t     operand_a;
  operand_t     operand_b;
  opcode_t      opcode;
  address_t     read_pointer;
  instruction_t instruction_word;

  logic [COUNT_W-1:0] count;
  logic         full;
  logic         empty;
  logic         flush;

  modport slave (
    input  req_valid, req_opcode, req_operand_a, req_operand_b, rd_ready,
           instruction_word, flush,
    output req_ready, rd_valid, rd_instruction, load_en, write_pointer,
           operand_a, operand_b, opcode, read_pointer, count, full, empty
  );

  modport master (
    output req_valid, req_opcode, req_operand_a, req_operand_b, rd_ready,
           instruction_word, flush,
    input  req_ready, rd_valid, rd_instruction, load_en, write_pointer,
           operand_a, operand_b, opcode, read_pointer, count, full, empty
  );

endinterface

// File: rtl/instr_register_ctrl_arb.sv
// Two-requester round-robin arbiter.
//   clk, reset : clock, synchronous active-high reset
//   req_i      : request vector
//   accept_i   : a grant was actually taken this cycle
//   gnt_o      : one-hot selection (combinational)
// last_q = 1 means requester 1 was granted last, so 0 wins the first contention.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_o = '0;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = '0;
    endcase
    last_d = last_q;
    if (accept_i) last_d = gnt_o[1];
  end

  always_ff @(posedge clk) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/instr_register_ctrl.sv
// Instruction register controller: arbitrates two writers into a 32-entry
// external register array used as a FIFO, and presents the oldest committed
// entry to a consumer.
//   clk, reset : clock, synchronous active-high reset
//   bus        : requests/grants, read handshake, register drive
//                (load_en, write_pointer, operands, opcode, read_pointer),
//                register read data, count/full/empty, flush
// A write is driven one cycle after its accept and counted one cycle later,
// when the register has actually captured it.
module instr_register_ctrl
  import instr_register_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 32
) (
  input logic                  clk,
  input logic                  reset,
  instr_register_ctrl_if.slave bus
);

  localparam count_t DEPTH = count_t'(NUM_ENTRIES);

  address_t wr_ptr_q, wr_ptr_d;
  address_t rd_ptr_q, rd_ptr_d;
  count_t   count_q, count_d;
  logic     load_en_q, load_en_d;
  address_t wp_q, wp_d;
  operand_t opa_q, opa_d;
  operand_t opb_q, opb_d;
  opcode_t  opc_q, opc_d;

  logic [1:0] gnt;
  logic [1:0] ready;
  logic       accept;
  logic       sel;
  logic       pop;
  logic       rd_valid;
  logic       full_or_pending;

  // An in-flight write (load_en_q) already owns a slot.
  assign full_or_pending = (count_q + count_t'(load_en_q)) == DEPTH;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .req_i    (bus.req_valid),
    .accept_i (accept),
    .gnt_o    (gnt)
  );

  always_comb begin
    ready = '0;
    if (!reset && !bus.flush && !full_or_pending) ready = bus.req_valid & gnt;
  end

  assign accept   = |ready;
  assign sel      = ready[1];
  assign rd_valid = !reset && (count_q != '0);
  assign pop      = rd_valid && bus.rd_ready;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    load_en_d = 1'b0;
    wp_d      = wp_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    opc_d     = opc_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (accept) begin
        load_en_d = 1'b1;
        wp_d      = wr_ptr_q;
        wr_ptr_d  = wr_ptr_q + address_t'(1);
        opc_d     = bus.req_opcode[sel];
        opa_d     = bus.req_operand_a[sel];
        opb_d     = bus.req_operand_b[sel];
      end
      if (pop) rd_ptr_d = rd_ptr_q + address_t'(1);
      count_d = count_q + count_t'(load_en_q) - count_t'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      load_en_q <= 1'b0;
      wp_q      <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      opc_q     <= ZERO;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      load_en_q <= load_en_d;
      wp_q      <= wp_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      opc_q     <= opc_d;
    end
  end

  assign bus.req_ready      = ready;
  assign bus.rd_valid       = rd_valid;
  assign bus.rd_instruction = bus.instruction_word;
  assign bus.load_en        = load_en_q;
  assign bus.write_pointer  = wp_q;
  assign bus.operand_a      = opa_q;
  assign bus.operand_b      = opb_q;
  assign bus.opcode         = opc_q;
  assign bus.read_pointer   = rd_ptr_q;
  assign bus.count          = count_q;
  assign bus.full           = (count_q == DEPTH);
  assign bus.empty          = (count_q == '0);

endmodule

// File: tb/tb_instr_register_ctrl.sv
// Self-checking bench for instr_register_ctrl: models the instruction
// register array, drives directed and random traffic, and compares every
// cycle against a queue-based reference of the committed entries.
module tb_instr_register_ctrl;
  import instr_register_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_register_ctrl_if bus ();

  instr_register_ctrl #(.NUM_ENTRIES(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Instruction register array driven by the controller.
  instruction_t mem [32];
  always @(posedge clk)
    if (bus.load_en)
      mem[bus.write_pointer] <= instruction_t'{bus.opcode, bus.operand_a, bus.operand_b};
  assign bus.instruction_word = mem[bus.read_pointer];

  // Reference model state.
  instruction_t m_fifo [$];
  bit           m_known = 1'b0;
  bit           m_pend;
  instruction_t m_pend_ins;
  int unsigned  m_wr, m_rd, m_wp;
  bit           m_pref1;
  instruction_t pl [2];
  bit           pl_taken [2];
  int           grant_log [$];

  int unsigned checks   = 0;
  int unsigned failures = 0;

  task automatic check_eq(input string tag, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic instruction_t rand_ins();
    instruction_t r;
    r.opc  = opcode_t'($urandom_range(0, 7));
    r.op_a = operand_t'($urandom);
    r.op_b = operand_t'($urandom);
    return r;
  endfunction

  task automatic step(input logic [1:0] v, input logic rr, input logic fl, input logic rst);
    logic [1:0] exp_rdy;
    bit         have;
    int         gi;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (pl_taken[i]) begin
        pl[i]       = rand_ins();
        pl_taken[i] = 1'b0;
      end
      bus.req_opcode[i]    = pl[i].opc;
      bus.req_operand_a[i] = pl[i].op_a;
      bus.req_operand_b[i] = pl[i].op_b;
    end
    bus.req_valid = v;
    bus.rd_ready  = rr;
    bus.flush     = fl;
    reset         = rst;
    #1;
    have    = m_fifo.size() > 0;
    exp_rdy = 2'b00;
    if (!rst && !fl && (m_fifo.size() + int'(m_pend)) < 32)
      exp_rdy = (v == 2'b11) ? (m_pref1 ? 2'b10 : 2'b01) : v;
    if (m_known) begin
      check_eq("req_ready",     bus.req_ready, exp_rdy);
      check_eq("rd_valid",      bus.rd_valid, !rst && have);
      check_eq("count",         bus.count, m_fifo.size());
      check_eq("full",          bus.full, m_fifo.size() == 32);
      check_eq("empty",         bus.empty, !have);
      check_eq("load_en",       bus.load_en, m_pend);
      check_eq("read_pointer",  bus.read_pointer, m_rd);
      check_eq("write_pointer", bus.write_pointer, m_wp);
      check_eq("load_payload",
               instruction_t'{bus.opcode, bus.operand_a, bus.operand_b}, m_pend_ins);
      if (!rst && have) check_eq("rd_instruction", bus.rd_instruction, m_fifo[0]);
    end
    @(posedge clk);
    if (rst) begin
      m_fifo.delete();
      m_pend     = 1'b0;
      m_pend_ins = '0;
      m_wr = 0; m_rd = 0; m_wp = 0;
      m_pref1    = 1'b0;
      m_known    = 1'b1;
    end else if (fl) begin
      m_fifo.delete();
      m_pend = 1'b0;
      m_wr = 0; m_rd = 0;
    end else begin
      if (have && rr) begin
        void'(m_fifo.pop_front());
        m_rd = (m_rd + 1) % 32;
      end
      if (m_pend) m_fifo.push_back(m_pend_ins);
      m_pend = 1'b0;
      if (exp_rdy != 2'b00) begin
        gi           = exp_rdy[1] ? 1 : 0;
        m_pend       = 1'b1;
        m_pend_ins   = pl[gi];
        m_wp         = m_wr;
        m_wr         = (m_wr + 1) % 32;
        m_pref1      = (gi == 0);
        pl_taken[gi] = 1'b1;
        grant_log.push_back(gi);
      end
    end
  endtask

  task automatic do_reset();
    step(2'b00, 1'b0, 1'b0, 1'b1);
    step(2'b00, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      pl[i]       = rand_ins();
      pl_taken[i] = 1'b0;
    end
    bus.req_valid = '0;
    bus.rd_ready  = 1'b0;
    bus.flush     = 1'b0;
    reset         = 1'b1;

    // Reset held two cycles, then released.
    do_reset();
    step(2'b00, 1'b0, 1'b0, 1'b0);
    #2;
    check_eq("rst_count",   bus.count, 0);
    check_eq("rst_empty",   bus.empty, 1);
    check_eq("rst_rdvalid", bus.rd_valid, 0);
    check_eq("rst_load_en", bus.load_en, 0);

    // Single write then read.
    pl[0] = instruction_t'{ADD, 32'sd5, 32'sd3};
    step(2'b01, 1'b0, 1'b0, 1'b0);
    #2;
    check_eq("single_load_en", bus.load_en, 1);
    check_eq("single_wp",      bus.write_pointer, 0);
    step(2'b00, 1'b0, 1'b0, 1'b0);
    #2;
    check_eq("single_count", bus.count, 1);
    check_eq("single_opc",   bus.rd_instruction.opc, ADD);
    check_eq("single_op_a",  bus.rd_instruction.op_a, 5);
    check_eq("single_op_b",  bus.rd_instruction.op_b, 3);
    step(2'b00, 1'b1, 1'b0, 1'b0);
    #2;
    check_eq("single_empty", bus.empty, 1);

    // Contention from reset: 0,1,0,1.
    do_reset();
    grant_log.delete();
    for (int i = 0; i < 4; i++) step(2'b11, 1'b0, 1'b0, 1'b0);
    #2;
    check_eq("contend_n", grant_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < grant_log.size()) check_eq("contend_order", grant_log[i], i % 2);
    check_eq("contend_wp", bus.write_pointer, 3);

    // Fill to 32, then pop one and reuse slot 0.
    do_reset();
    for (int i = 0; i < 40; i++) step(2'($urandom_range(1, 3)), 1'b0, 1'b0, 1'b0);
    #2;
    check_eq("full_flag",  bus.full, 1);
    check_eq("full_ready", bus.req_ready, 0);
    step(2'b01, 1'b1, 1'b0, 1'b0);
    step(2'b01, 1'b0, 1'b0, 1'b0);
    #2;
    check_eq("wrap_wp", bus.write_pointer, 0);
    step(2'b00, 1'b0, 1'b0, 1'b0);
    #2;
    check_eq("wrap_count", bus.count, 32);

    // Simultaneous commit and pop at count 5.
    do_reset();
    for (int i = 0; i < 5; i++) step(2'b10, 1'b0, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0, 1'b0);
    #2;
    check_eq("simul_pre", bus.count, 5);
    step(2'b10, 1'b0, 1'b0, 1'b0);
    step(2'b00, 1'b1, 1'b0, 1'b0);
    #2;
    check_eq("simul_count", bus.count, 5);
    check_eq("simul_rdptr", bus.read_pointer, 1);
    check_eq("simul_wp",    bus.write_pointer, 5);

    // Flush in the cycle after an accept.
    step(2'b01, 1'b0, 1'b0, 1'b0);
    step(2'b01, 1'b0, 1'b1, 1'b0);
    #2;
    check_eq("flush_load_en", bus.load_en, 0);
    check_eq("flush_count",   bus.count, 0);
    step(2'b01, 1'b0, 1'b0, 1'b0);
    #2;
    check_eq("flush_wp", bus.write_pointer, 0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 800; i++)
      step(2'($urandom),
           (i < 300) ? ($urandom_range(0, 3) == 0) : 1'($urandom),
           $urandom_range(0, 49) == 0,
           $urandom_range(0, 199) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_register_ctrl.md
INSTR_REGISTER_CTRL -- requirements
Module: instr_register_ctrl

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 32, meaning instruction register depth; the only supported value is 32.
REQ-002 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port req_valid, input, 2, write request per requester (index 0, 1).
REQ-005 SHALL have ports req_opcode[2], req_operand_a[2], req_operand_b[2], input, opcode_t/operand_t each, payload per requester.
REQ-006 SHALL have port req_ready, output, 2, grant per requester.
REQ-007 SHALL have port rd_valid, output, 1, oldest committed entry available.
REQ-008 SHALL have port rd_ready, input, 1, consumer accepts entry.
REQ-009 SHALL have port rd_instruction, output, instruction_t, equals instruction_word while rd_valid.
REQ-010 SHALL have ports load_en, write_pointer, operand_a, operand_b, opcode, read_pointer, output, 1/address_t/operand_t/operand_t/opcode_t/address_t, driving the instruction register.
REQ-011 SHALL have port instruction_word, input, instruction_t, combinational read of the register at read_pointer.
REQ-012 SHALL have ports count, output, 6, committed entries; full, output, 1; empty, output, 1.
REQ-013 SHALL have port flush, input, 1, discards all entries.

Function
REQ-014 SHALL grant at most one requester per cycle: req_ready[i] = req_valid[i] and not full_or_pending and round-robin selection.
REQ-015 SHALL use round-robin arbitration with a last-grant flag: on contention, grant the requester not granted last; a lone requester is always granted when space exists.
REQ-016 SHALL, on an accept at edge T, register load_en=1, write_pointer=wr_ptr, and the granted payload, visible after edge T; load_en SHALL be 0 in cycles with no accept.
REQ-017 SHALL increment wr_ptr modulo 32 on each accept (31 -> 0).
REQ-018 SHALL increment count at the edge where load_en is sampled high (T+1), so rd_valid for the entry rises one cycle after the write is driven.
REQ-019 SHALL compute full_or_pending as count + inflight write == 32; full = (count == 32); empty = (count == 0).
REQ-020 SHALL drive read_pointer = rd_ptr continuously, and assert rd_valid = not empty.
REQ-021 SHALL pop on rd_valid and rd_ready at an edge: rd_ptr increments modulo 32, and count decrements.
REQ-022 SHALL leave count unchanged on a simultaneous commit and pop; both pointers SHALL advance.
REQ-023 SHALL ignore rd_ready while empty, and SHALL ignore req_valid while full_or_pending; neither case changes state.
REQ-024 SHALL hold req payload and arbitration unchanged while no accept occurs; requesters keep valid asserted until ready.
REQ-025 SHALL, on flush at an edge, zero wr_ptr, rd_ptr and count, and clear load_en, dropping any inflight write; flush SHALL force req_ready=0 in its cycle.

Reset
REQ-026 SHALL, on reset at an edge, set wr_ptr=0, rd_ptr=0, count=0, load_en=0, write_pointer=0, operands=0, opcode=ZERO, and last-grant=1 so requester 0 wins first contention.
REQ-027 SHALL give reset priority over flush, accept and pop in the same cycle; req_ready=0 and rd_valid=0 while reset is high.

Structure
REQ-028 SHALL take opcode_t, operand_t, address_t and instruction_t from instr_register_pkg, and SHALL add a localparam for the 6-bit count width there.
REQ-029 SHALL instantiate one sub-module rr_arbiter2, a 2-requester round-robin grant with last-grant state; all other logic is flat.

Verification
REQ-030 Reset: reset held 2 cycles, then released -> count=0, empty=1, rd_valid=0, load_en=0, req_ready=00.
REQ-031 Single write/read: req_valid=01 with ADD, a=5, b=3 -> load_en=1 with write_pointer=0 next cycle, count=1 one cycle later, rd_instruction.opc=ADD, op_a=5, op_b=3; rd_ready=1 -> empty=1.
REQ-032 Contention: req_valid=11 held for 4 accepts -> grant order 0,1,0,1, with write_pointers 0..3.
REQ-033 Full/wrap: 32 writes with no reads -> full=1 and req_ready=00; one pop plus one write -> write_pointer=0 reused, count=32.
REQ-034 Simultaneous: count=5 with a commit and a pop in the same cycle -> count stays 5, and rd_ptr and wr_ptr both advance.
REQ-035 Flush mid-write: flush in the cycle after an accept -> load_en=0 next cycle, count=0, and the next write uses write_pointer=0.
